// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths, default frame size and Sobel kernel weights.
// Imported by sobel_pixel_counter and sobel_gradient_compute.
package sobel_pkg;

    localparam int PIXEL_W        = 8;
    localparam int SUM_W          = 10;
    localparam int MAG_W          = 11;
    localparam int PIXEL_MAX      = 255;
    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;

    localparam int K_SIDE = 1;
    localparam int K_MID  = 2;

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef logic [SUM_W-1:0]   sum_t;
    typedef logic [MAG_W-1:0]   mag_t;

    typedef struct packed {
        sum_t gx_p;
        sum_t gx_n;
        sum_t gy_p;
        sum_t gy_n;
        logic border;
        logic last;
    } s1_t;

    // One side of a kernel: side taps weighted 1, middle tap weighted 2
    function automatic sum_t tap_sum(pixel_t a, pixel_t m, pixel_t b);
        return sum_t'(a) * sum_t'(K_SIDE)
             + sum_t'(m) * sum_t'(K_MID)
             + sum_t'(b) * sum_t'(K_SIDE);
    endfunction

    function automatic sum_t abs_diff(sum_t p, sum_t n);
        return (p >= n) ? p - n : n - p;
    endfunction

endpackage

// File: rtl/sobel_pixel_counter.sv
// sobel_pixel_counter: col/row position of the incoming window stream,
// advancing on done; flags the image border and the last pixel of a frame.
module sobel_pixel_counter
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic clk,
    input  logic rst,
    input  logic done,
    output logic border,
    output logic last
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_end;
    logic          row_end;

    assign col_end = (col == COL_LAST);
    assign row_end = (row == ROW_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (done) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign border = (col == '0) | col_end | (row == '0) | row_end;
    assign last   = col_end & row_end;

endmodule

// File: rtl/sobel_gradient_compute.sv
// sobel_gradient_compute: 3-stage Sobel |Gx|+|Gy| with border zeroing.
// Optional binarization against THRESHOLD under `define SOBEL_THRESHOLD_EN.
module sobel_gradient_compute
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int THRESHOLD  = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIXEL_W-1:0] d0_i,
    input  logic [PIXEL_W-1:0] d1_i,
    input  logic [PIXEL_W-1:0] d2_i,
    input  logic [PIXEL_W-1:0] d3_i,
    input  logic [PIXEL_W-1:0] d4_i,
    input  logic [PIXEL_W-1:0] d5_i,
    input  logic [PIXEL_W-1:0] d6_i,
    input  logic [PIXEL_W-1:0] d7_i,
    input  logic [PIXEL_W-1:0] d8_i,
    input  logic               done_i,
    output logic [PIXEL_W-1:0] pixel_o,
    output logic               done_o,
    output logic               frame_done_o
);

    logic   border_now;
    logic   last_now;
    s1_t    s1;
    logic   v1;
    sum_t   ax;
    sum_t   ay;
    logic   b2;
    logic   l2;
    logic   v2;
    mag_t   mag;
    pixel_t sat;
    pixel_t result;

    // The centre tap carries zero weight in both kernels
    logic unused_centre;
    assign unused_centre = ^d4_i;

    sobel_pixel_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .done  (done_i),
        .border(border_now),
        .last  (last_now)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1           <= 1'b0;
            v2           <= 1'b0;
            done_o       <= 1'b0;
            frame_done_o <= 1'b0;
            pixel_o      <= '0;
        end else begin
            v1           <= done_i;
            v2           <= v1;
            done_o       <= v2;
            frame_done_o <= v2 & l2;
            if (v2) pixel_o <= result;
        end
    end

    // Datapath registers only move with their valid bit
    always_ff @(posedge clk) begin
        if (done_i) begin
            s1.gx_p   <= tap_sum(d2_i, d5_i, d8_i);
            s1.gx_n   <= tap_sum(d0_i, d3_i, d6_i);
            s1.gy_p   <= tap_sum(d6_i, d7_i, d8_i);
            s1.gy_n   <= tap_sum(d0_i, d1_i, d2_i);
            s1.border <= border_now;
            s1.last   <= last_now;
        end
        if (v1) begin
            ax <= abs_diff(s1.gx_p, s1.gx_n);
            ay <= abs_diff(s1.gy_p, s1.gy_n);
            b2 <= s1.border;
            l2 <= s1.last;
        end
    end

    always_comb begin
        result = '0;
        mag    = mag_t'(ax) + mag_t'(ay);
        sat    = (mag > mag_t'(PIXEL_MAX)) ? pixel_t'(PIXEL_MAX)
                                           : mag[PIXEL_W-1:0];
`ifdef SOBEL_THRESHOLD_EN
        result = (sat >= pixel_t'(THRESHOLD)) ? pixel_t'(PIXEL_MAX) : '0;
`else
        result = sat;
`endif
        if (b2) result = '0;
    end

`ifndef SOBEL_THRESHOLD_EN
    localparam int unused_threshold = THRESHOLD;
`endif

endmodule
